aukv_muldiv: RTL and testbench

AUKV_MULDIV -- requirements
Module: aukv_muldiv

---
 rtl/aukv_muldiv.sv | 179 +++++++++++++++++
 tb/tb_aukv_muldiv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aukv_muldiv.sv
// aukv_muldiv -- iterative RV32/64 M-extension multiply/divide unit.
//
// Multiply: radix-2 shift-add on operand magnitudes, XLEN cycles, sign
// applied to the 2*XLEN-bit product on the last iteration.
// Divide:   restoring, one quotient bit per cycle on magnitudes; zero
// divisor and signed overflow are resolved at accept without iterating.
//
// Build option: define AUKV_MULDIV_DIV_EN to include the divider. Without
// it, ops 4..7 complete one cycle after accept with o_rd=0, o_err=1.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   request handshake (i_op, i_rs1, i_rs2)
//   i_flush             abandon in-flight or completed operation
//   o_valid / i_ready   result handshake (o_rd, o_err)
module aukv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_rd,
    output logic            o_err
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     opb_mag;   // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc;       // {hi, lo}: product, or {remainder, quotient}
    logic                neg_q;     // negate product / quotient at the end

    // Operand signedness for the incoming request. MUL only uses the low
    // half, which is identical for signed and unsigned operands.
    logic            rs1_sgn, rs2_sgn;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        rs1_sgn = i_rs1[XLEN-1] && (i_op == 3'd1 || i_op == 3'd2 ||
                                    i_op == 3'd4 || i_op == 3'd6);
        rs2_sgn = i_rs2[XLEN-1] && (i_op == 3'd1 || i_op == 3'd4 ||
                                    i_op == 3'd6);
        a_mag   = rs1_sgn ? -i_rs1 : i_rs1;
        b_mag   = rs2_sgn ? -i_rs2 : i_rs2;
    end

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier bit (acc[0]) is set, then shift right by one.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fix;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_mag} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        mul_fix  = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 2'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    end

`ifdef AUKV_MULDIV_DIV_EN
    logic              is_div_q;
    logic              neg_r;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo, rem, div_res;
    logic              div_zero, div_ovf;

    // Restoring step: shift {rem, dividend} left, try subtracting the
    // divisor, keep the difference and set the quotient bit if it fits.
    always_comb begin
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_mag};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
        quo       = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem       = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        div_res   = op_q[1] ? rem : quo;
        div_zero  = (i_rs2 == '0);
        div_ovf   = !i_op[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
    end
`endif

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            opb_mag <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            o_rd    <= '0;
            o_err   <= 1'b0;
`ifdef AUKV_MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && !i_flush) begin
                        op_q    <= i_op[1:0];
                        opb_mag <= b_mag;
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        neg_q   <= rs1_sgn ^ rs2_sgn;
                        cnt     <= '0;
`ifdef AUKV_MULDIV_DIV_EN
                        is_div_q <= i_op[2];
                        neg_r    <= rs1_sgn;
                        if (i_op[2] && div_zero) begin
                            state <= DONE;
                            o_rd  <= i_op[1] ? i_rs1 : '1;
                        end else if (i_op[2] && div_ovf) begin
                            state <= DONE;
                            o_rd  <= i_op[1] ? '0 : i_rs1;
                        end else begin
                            state <= CALC;
                        end
`else
                        if (i_op[2]) begin
                            state <= DONE;
                            o_rd  <= '0;
                            o_err <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
`endif
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
`ifdef AUKV_MULDIV_DIV_EN
                        acc <= is_div_q ? div_next : mul_next;
`else
                        acc <= mul_next;
`endif
                        // Final iteration: sign-correct the value being
                        // produced this cycle so DONE needs no extra step.
                        if (cnt == CW'(XLEN-1)) begin
                            state <= DONE;
                            cnt   <= '0;
`ifdef AUKV_MULDIV_DIV_EN
                            o_rd  <= is_div_q ? div_res : mul_res;
`else
                            o_rd  <= mul_res;
`endif
                        end
                    end
                end
                DONE: begin
                    if (i_flush || i_ready) begin
                        state <= IDLE;
                        o_rd  <= '0;
                        o_err <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aukv_muldiv.sv
module tb_aukv_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            out_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1, rs2;
    logic            flush;
    logic            out_valid;
    logic            cons_ready;
    logic [XLEN-1:0] rd;
    logic            err;

    int total = 0;
    int bad   = 0;

    aukv_muldiv #(.XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_op    (op),
        .i_rs1   (rs1),
        .i_rs2   (rs2),
        .i_flush (flush),
        .o_valid (out_valid),
        .i_ready (cons_ready),
        .o_rd    (rd),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input logic ee, input int l);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e; v.exp_err = ee; v.lat = l;
        vecs.push_back(v);
    endfunction

    // Issue one request; returns result and cycles from accept to o_valid.
    // Operands are scrambled right after accept to show they were captured.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e, output int lat);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rs1 = ~a; rs2 = ~b; op = ~o;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = rd; e = err;
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        cons_ready = 1'b1;
        @(posedge clk); #1;
        cons_ready = 1'b0;
        chk({name, "_ready"}, 64'(out_ready), 64'd1);
        chk({name, "_vlow"},  64'(out_valid), 64'd0);
        chk({name, "_rd0"},   64'(rd),        64'd0);
    endtask

    logic [31:0] r, held;
    logic        e;
    int          lat, seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        flush = 1'b0; cons_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(out_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd",    64'(rd),        64'd0);
        chk("rst_err",   64'(err),       64'd0);

        add(3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
        add(3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0, 33);
        add(3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        add(3'd2, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0, 33);
        add(3'd0, 32'h00012345,  32'h10,       32'h00123450, 1'b0, 33);
        add(3'd3, 32'h80000000,  32'd4,        32'h00000002, 1'b0, 33);
`ifdef AUKV_MULDIV_DIV_EN
        add(3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0, 33);
        add(3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0, 33);
        add(3'd5, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 1'b0, 33);
        add(3'd7, 32'hFFFFFFF9,  32'd2,        32'h00000001, 1'b0, 33);
        add(3'd4, 32'd100,       32'd7,        32'd14,       1'b0, 33);
        add(3'd6, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 1'b0, 33);
        add(3'd5, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b0, 33);
        add(3'd7, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
        add(3'd5, 32'd9,         32'd0,        32'hFFFFFFFF, 1'b0, 1);
        add(3'd6, 32'd5,         32'd0,        32'd5,        1'b0, 1);
        add(3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        add(3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b0, 1);
`else
        add(3'd4, 32'd6,         32'd3,        32'd0,        1'b1, 1);
        add(3'd5, 32'd9,         32'd0,        32'd0,        1'b1, 1);
        add(3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b1, 1);
        add(3'd7, 32'd100,       32'd7,        32'd0,        1'b1, 1);
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat);
            chk($sformatf("v%0d_rd", i),  64'(r),   64'(vecs[i].exp));
            chk($sformatf("v%0d_err", i), 64'(e),   64'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            release_result($sformatf("v%0d", i));
        end

        // Result held for 10 cycles without consumer ready.
        run_op(3'd0, 32'd3, 32'd5, held, e, lat);
        chk("hold_first", 64'(held), 64'd15);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rd !== 32'd15 || out_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        chk("hold_stable", 64'(seen), 64'd0);
        release_result("hold");

        // Flush at iteration 5.
        @(negedge clk);
        op = 3'd0; rs1 = 32'd11; rs2 = 32'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 64'(out_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_novalid", 64'(seen), 64'd0);

        // Reset at iteration 20.
        @(negedge clk);
        op = 3'd3; rs1 = 32'd11; rs2 = 32'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 64'(out_ready), 64'd1);
        chk("midrst_rd",    64'(rd),        64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_novalid", 64'(seen), 64'd0);

        // Flush in IDLE blocks the accept.
        @(negedge clk);
        op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idleflush_ready", 64'(out_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("idleflush_novalid", 64'(seen), 64'd0);

        // Flush and consumer ready together in DONE.
        run_op(3'd0, 32'd6, 32'd7, r, e, lat);
        chk("fr_rd", 64'(r), 64'd42);
        @(negedge clk);
        flush = 1'b1; cons_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; cons_ready = 1'b0;
        chk("fr_valid", 64'(out_valid), 64'd0);
        chk("fr_ready", 64'(out_ready), 64'd1);
        chk("fr_rd0",   64'(rd),        64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
